lshift_pipe: RTL and testbench

- Pipelined left barrel shifter with a valid/ready handshake on both sides.
- Supports logical left shift (zero fill) and rotate-left.
- Complements the existing combinational arithmetic right shifter, so the datapath has both shift directions.
- Uses one registered stage per shift-amount bit, giving full throughput (1 op/cycle) with backpressure.

---
 rtl/lshift_pipe.sv | 127 ++++++++++++
 tb/tb_lshift_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lshift_pipe.sv
// Pipelined left barrel shifter (logical / rotate) with valid/ready on both sides.
// Define LSHIFT_CARRY_EN to add the carry output and its per-stage registers.
module lshift_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   sel,
  input  logic             rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef LSHIFT_CARRY_EN
  ,
  output logic             carry
`endif
);

  logic [WIDTH-1:0]   data_q   [SHW];
  logic [SHW-1:0]     sel_q    [SHW];
  logic [SHW-1:0]     rot_q;
  logic [SHW-1:0]     valid_q;
  logic [SHW-1:0]     ready;

  // Stage inputs: index 0 is the block input, index k>0 is stage k-1's register.
  logic [WIDTH-1:0]   src_data [SHW];
  logic [SHW-1:0]     src_sel  [SHW];
  logic [SHW-1:0]     src_rot;
  logic [SHW-1:0]     src_valid;
  logic [WIDTH-1:0]   nxt_data [SHW];
  logic [2*WIDTH-1:0] wide;

`ifdef LSHIFT_CARRY_EN
  logic [SHW-1:0]     carry_q;
  logic [SHW-1:0]     src_carry;
  logic [SHW-1:0]     nxt_carry;
`endif

  // ready_k = !valid_k || ready_(k+1) unrolled into an OR over downstream
  // stages so the chain has no self-referencing combinational vector.
  always_comb begin
    ready = '0;
    for (int unsigned k = 0; k < SHW; k++) begin
      ready[k] = out_ready;
      for (int unsigned j = k; j < SHW; j++) begin
        ready[k] = ready[k] | ~valid_q[j];
      end
    end
  end

  always_comb begin
    src_data[0]  = in;
    src_sel[0]   = sel;
    src_rot[0]   = rot;
    src_valid[0] = in_valid;
    for (int unsigned k = 1; k < SHW; k++) begin
      src_data[k]  = data_q[k-1];
      src_sel[k]   = sel_q[k-1];
      src_rot[k]   = rot_q[k-1];
      src_valid[k] = valid_q[k-1];
    end
  end

`ifdef LSHIFT_CARRY_EN
  always_comb begin
    src_carry[0] = 1'b0;
    for (int unsigned k = 1; k < SHW; k++) begin
      src_carry[k] = carry_q[k-1];
    end
  end
`endif

  // Upper half of the widened shift holds the bits pushed past the MSB:
  // they feed the rotate wrap-around, and wide[WIDTH] is the last bit out.
  always_comb begin
    wide = '0;
`ifdef LSHIFT_CARRY_EN
    nxt_carry = '0;
`endif
    for (int unsigned k = 0; k < SHW; k++) begin
      wide = {{WIDTH{1'b0}}, src_data[k]} << (src_sel[k][k] ? (32'd1 << k) : 32'd0);
      nxt_data[k] = src_rot[k] ? (wide[WIDTH-1:0] | wide[2*WIDTH-1:WIDTH])
                               : wide[WIDTH-1:0];
`ifdef LSHIFT_CARRY_EN
      nxt_carry[k] = src_sel[k][k] ? wide[WIDTH] : src_carry[k];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
        sel_q[k]  <= '0;
      end
      rot_q   <= '0;
      valid_q <= '0;
`ifdef LSHIFT_CARRY_EN
      carry_q <= '0;
`endif
    end else begin
      for (int unsigned k = 0; k < SHW; k++) begin
        if (ready[k]) begin
          valid_q[k] <= src_valid[k];
          data_q[k]  <= nxt_data[k];
          sel_q[k]   <= src_sel[k];
          rot_q[k]   <= src_rot[k];
`ifdef LSHIFT_CARRY_EN
          carry_q[k] <= nxt_carry[k];
`endif
        end
      end
    end
  end

  assign in_ready  = ready[0] & ~rst;
  assign out_valid = valid_q[SHW-1];
  assign out       = data_q[SHW-1];
`ifdef LSHIFT_CARRY_EN
  assign carry     = carry_q[SHW-1];
`endif

endmodule

// File: tb/tb_lshift_pipe.sv
// Directed bench for lshift_pipe (WIDTH=8, SHW=3); carry is checked only
// when LSHIFT_CARRY_EN is defined.
module tb_lshift_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] sel;
  logic       rot;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef LSHIFT_CARRY_EN
  logic       carry;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  lshift_pipe #(.WIDTH(8), .SHW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_data),
    .sel       (sel),
    .rot       (rot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_data)
`ifdef LSHIFT_CARRY_EN
    ,
    .carry     (carry)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_carry(input string tag, input logic exp);
`ifdef LSHIFT_CARRY_EN
    chk(tag, 32'(carry), 32'(exp));
`else
    if (exp === 1'bx) $display("unreachable %s", tag);
`endif
  endtask

  task automatic run_op(input string tag, input logic [7:0] d, input logic [2:0] s,
                        input logic r, input logic [7:0] eo, input logic ec);
    in_data  = d;
    sel      = s;
    rot      = r;
    in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, ".lat2"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out"}, 32'(out_data), 32'(eo));
    chk_carry({tag, ".carry"}, ec);
    tick();
    chk({tag, ".drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    sel       = '0;
    rot       = 1'b0;
    out_ready = 1'b1;

    tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out", 32'(out_data), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk_carry("rst.carry", 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    run_op("lsl81_1", 8'h81, 3'd1, 1'b0, 8'h02, 1'b1);
    run_op("rol81_1", 8'h81, 3'd1, 1'b1, 8'h03, 1'b1);
    run_op("lslB4_3", 8'hB4, 3'd3, 1'b0, 8'hA0, 1'b1);
    run_op("rolB4_3", 8'hB4, 3'd3, 1'b1, 8'hA5, 1'b1);
    run_op("lslB4_0", 8'hB4, 3'd0, 1'b0, 8'hB4, 1'b0);
    run_op("rolB4_0", 8'hB4, 3'd0, 1'b1, 8'hB4, 1'b0);
    run_op("lslFF_7", 8'hFF, 3'd7, 1'b0, 8'h80, 1'b1);
    run_op("rol01_7", 8'h01, 3'd7, 1'b1, 8'h80, 1'b0);

    // Throughput: one op per cycle, results two edges after each accept edge
    for (int i = 0; i <= 10; i++) begin
      if (i < 8) begin
        in_data  = 8'h01;
        sel      = 3'(i);
        rot      = 1'b0;
        in_valid = 1'b1;
        chk($sformatf("tput.in_ready%0d", i), 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 2 && i < 10) begin
        chk($sformatf("tput.valid%0d", i), 32'(out_valid), 32'd1);
        chk($sformatf("tput.out%0d", i), 32'(out_data), 32'd1 << (i - 2));
        chk_carry($sformatf("tput.carry%0d", i), 1'b0);
      end else begin
        chk($sformatf("tput.idle%0d", i), 32'(out_valid), 32'd0);
      end
    end

    // Backpressure
    out_ready = 1'b0;
    rot       = 1'b0;
    in_data   = 8'h01;
    sel = 3'd1; in_valid = 1'b1;
    chk("bp.rdyA", 32'(in_ready), 32'd1);
    tick();
    sel = 3'd2;
    chk("bp.rdyB", 32'(in_ready), 32'd1);
    tick();
    sel = 3'd3;
    chk("bp.rdyC", 32'(in_ready), 32'd1);
    tick();
    sel = 3'd4;
    chk("bp.full", 32'(in_ready), 32'd0);
    chk("bp.valid0", 32'(out_valid), 32'd1);
    chk("bp.out0", 32'(out_data), 32'h02);
    tick();
    chk("bp.hold1.out", 32'(out_data), 32'h02);
    chk("bp.hold1.valid", 32'(out_valid), 32'd1);
    chk("bp.hold1.rdy", 32'(in_ready), 32'd0);
    tick();
    chk("bp.hold2.out", 32'(out_data), 32'h02);
    out_ready = 1'b1;
    #1;
    chk("bp.release.rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.r1.valid", 32'(out_valid), 32'd1);
    chk("bp.r1.out", 32'(out_data), 32'h04);
    tick();
    chk("bp.r2.out", 32'(out_data), 32'h08);
    tick();
    chk("bp.r3.valid", 32'(out_valid), 32'd1);
    chk("bp.r3.out", 32'(out_data), 32'h10);
    tick();
    chk("bp.empty", 32'(out_valid), 32'd0);
    chk("bp.retain", 32'(out_data), 32'h10);

    // Reset mid-operation, asserted and released away from the clock edge
    in_data = 8'hFF; sel = 3'd1; rot = 1'b0; in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst.valid", 32'(out_valid), 32'd0);
    chk("mid_rst.out", 32'(out_data), 32'd0);
    chk("mid_rst.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("after_rst.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("after_rst.valid%0d", i), 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
